rx_fsm: RTL and testbench

UART receiver FSM, the receive-side counterpart of the lab's `tx_fsm` transmitter. It deserialises an asynchronous 8N1 serial line (`rxd`) into parallel bytes. Each bit is sampled at its midpoint using a per-bit clock counter. Each completed frame produces a one-cycle `valid` strobe, or an error strobe. It sits between the board RX pin and the byte consumer, typically a loopback to `tx_fsm` in the lab top level.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/rx_bit_timer.sv | 47 ++++
 rtl/rx_fsm.sv | 173 +++++++++++++++++
 tb/tb_rx_fsm.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the lab UART blocks (rx_fsm, tx_fsm).
//
// Contents:
//   DEFAULT_CLKS_PER_BIT  system clocks per bit (50 MHz / 115200)
//   DATA_BITS, FRAME_BITS_* frame length constants
//   uart_state_e          4-bit state encodings s0..s11
//   parity_bad()          even-parity check over data plus parity bit

package uart_pkg;

   localparam int DEFAULT_CLKS_PER_BIT = 434;
   localparam int DATA_BITS            = 8;
   localparam int FRAME_BITS_8N1       = 10;
   localparam int FRAME_BITS_8E1       = 11;

   // s11 is only reachable when parity is compiled in
   typedef enum logic [3:0] {
      S0_IDLE    = 4'd0,
      S1_START   = 4'd1,
      S2_DATA0   = 4'd2,
      S3_DATA1   = 4'd3,
      S4_DATA2   = 4'd4,
      S5_DATA3   = 4'd5,
      S6_DATA4   = 4'd6,
      S7_DATA5   = 4'd7,
      S8_DATA6   = 4'd8,
      S9_DATA7   = 4'd9,
      S10_STOP   = 4'd10,
      S11_PARITY = 4'd11
   } uart_state_e;

   // Even parity: XOR over all data bits and the parity bit must be 0
   function automatic logic parity_bad(input logic [DATA_BITS-1:0] data,
                                       input logic par);
      return (^data) ^ par;
   endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer
// Per-bit clock counter for the UART receiver. Produces terminal-count
// pulses at the half-bit point (start-bit check) and the full-bit point
// (data/parity/stop midpoints, since counting restarts at a midpoint).
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   clr       hold counter at 0 (FSM idle)
//   half_sel  1 = count to CLKS_PER_BIT/2-1, 0 = count to CLKS_PER_BIT-1
//   half_tc   half-bit terminal count reached this cycle
//   full_tc   full-bit terminal count reached this cycle
//   baud_en   sample strobe, high in the cycle the FSM samples rxd

module rx_bit_timer #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic half_sel,
   output logic half_tc,
   output logic full_tc,
   output logic baud_en
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Every sample is followed by a state change, so the counter
   // restarts from 0 on each terminal count as well as while idle
   always_comb begin
      half_tc = !clr &&  half_sel && (cnt_q == HALF_LAST);
      full_tc = !clr && !half_sel && (cnt_q == FULL_LAST);
      baud_en = half_tc | full_tc;
      cnt_d   = (clr || baud_en) ? '0 : cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/rx_fsm.sv
// rx_fsm
// UART receiver: deserialises an asynchronous serial line into bytes,
// sampling each bit at its midpoint. 8N1 by default; defining the macro
// RX_PARITY_EN switches to 8E1 with a parity-error strobe.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   rxd        serial input, idles high, asynchronous to clk
//   en         enables start-bit detection (a started frame always completes)
//   dout       last correctly received byte
//   valid      one-cycle pulse when dout is updated
//   frame_err  one-cycle pulse when the stop bit was sampled low
//   par_err    one-cycle pulse on parity mismatch (0 without RX_PARITY_EN)
//   baud_en    one-cycle pulse at every bit sample point
//   busy       high whenever the receiver is not idle

module rx_fsm
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rxd,
   input  logic       en,
   output logic [7:0] dout,
   output logic       valid,
   output logic       frame_err,
   output logic       par_err,
   output logic       baud_en,
   output logic       busy
);

   uart_state_e state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  dout_q, dout_d;
   logic        valid_q, valid_d;
   logic        frame_err_q, frame_err_d;
   logic        busy_q, busy_d;
   logic        rxd_meta_q, rxd_meta_d;
   logic        rxd_s_q, rxd_s_d;
   logic        stop_par_bad;
   logic        half_tc, full_tc;
`ifdef RX_PARITY_EN
   logic        par_bit_q, par_bit_d;
   logic        par_err_q, par_err_d;
`endif

   rx_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .clr      (state_q == S0_IDLE),
      .half_sel (state_q == S1_START),
      .half_tc  (half_tc),
      .full_tc  (full_tc),
      .baud_en  (baud_en)
   );

   always_comb begin
      rxd_meta_d  = rxd;
      rxd_s_d     = rxd_meta_q;
      state_d     = state_q;
      shift_d     = shift_q;
      dout_d      = dout_q;
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
`ifdef RX_PARITY_EN
      par_bit_d    = par_bit_q;
      par_err_d    = 1'b0;
      stop_par_bad = parity_bad(shift_q, par_bit_q);
`else
      stop_par_bad = 1'b0;
`endif

      unique case (state_q)
         S0_IDLE: begin
            if (en && !rxd_s_q) state_d = S1_START;
         end
         S1_START: begin
            // A start bit that is no longer low at its midpoint was noise
            if (half_tc) state_d = rxd_s_q ? S0_IDLE : S2_DATA0;
         end
         S2_DATA0, S3_DATA1, S4_DATA2, S5_DATA3,
         S6_DATA4, S7_DATA5, S8_DATA6, S9_DATA7: begin
            if (full_tc) begin
               // LSB arrives first, so shifting in at the top leaves bit 0 at [0]
               shift_d = {rxd_s_q, shift_q[7:1]};
               if (state_q == S9_DATA7) begin
`ifdef RX_PARITY_EN
                  state_d = S11_PARITY;
`else
                  state_d = S10_STOP;
`endif
               end else begin
                  state_d = uart_state_e'(state_q + 4'd1);
               end
            end
         end
`ifdef RX_PARITY_EN
         S11_PARITY: begin
            if (full_tc) begin
               par_bit_d = rxd_s_q;
               state_d   = S10_STOP;
            end
         end
`endif
         S10_STOP: begin
            // Leave at the stop-bit midpoint so an immediately following
            // start bit is caught from its falling edge
            if (full_tc) begin
               state_d = S0_IDLE;
`ifdef RX_PARITY_EN
               par_err_d = stop_par_bad;
`endif
               if (!rxd_s_q) begin
                  frame_err_d = 1'b1;
               end else if (!stop_par_bad) begin
                  valid_d = 1'b1;
                  dout_d  = shift_q;
               end
            end
         end
         default: state_d = S0_IDLE;
      endcase

      busy_d = (state_d != S0_IDLE);
   end

   // Single register stage for the whole receiver, outputs included
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rxd_meta_q  <= 1'b1;
         rxd_s_q     <= 1'b1;
         state_q     <= S0_IDLE;
         shift_q     <= 8'h00;
         dout_q      <= 8'h00;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef RX_PARITY_EN
         par_bit_q   <= 1'b0;
         par_err_q   <= 1'b0;
`endif
      end else begin
         rxd_meta_q  <= rxd_meta_d;
         rxd_s_q     <= rxd_s_d;
         state_q     <= state_d;
         shift_q     <= shift_d;
         dout_q      <= dout_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         busy_q      <= busy_d;
`ifdef RX_PARITY_EN
         par_bit_q   <= par_bit_d;
         par_err_q   <= par_err_d;
`endif
      end
   end

   assign dout      = dout_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign busy      = busy_q;
`ifdef RX_PARITY_EN
   assign par_err   = par_err_q;
`else
   assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_rx_fsm.sv
// tb_rx_fsm
// Directed bench for rx_fsm at 16 clocks per bit with a 20 ns clock.
// Build with RX_PARITY_EN defined to exercise the 8E1 variant.

module tb_rx_fsm;

   localparam int CPB = 16;
`ifdef RX_PARITY_EN
   localparam int BAUD_GOOD = 11;
   localparam int LATENCY   = 2 + CPB / 2 + 10 * CPB + 1;
`else
   localparam int BAUD_GOOD = 10;
   localparam int LATENCY   = 2 + CPB / 2 + 9 * CPB + 1;
`endif

   logic       clk;
   logic       reset;
   logic       rxd;
   logic       en;
   logic [7:0] dout;
   logic       valid;
   logic       frame_err;
   logic       par_err;
   logic       baud_en;
   logic       busy;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int baud_cnt = 0;
   int valid_cnt = 0;
   int ferr_cnt = 0;
   int perr_cnt = 0;
   int busy_cnt = 0;
   int both_cnt = 0;
   int last_valid_cyc = 0;
   logic [7:0] last_valid_dout = 8'h00;
   int last_start_cyc = 0;

   rx_fsm #(
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .en        (en),
      .dout      (dout),
      .valid     (valid),
      .frame_err (frame_err),
      .par_err   (par_err),
      .baud_en   (baud_en),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event tallies sampled mid-cycle, away from the active edge
   always @(negedge clk) begin
      if (baud_en) baud_cnt = baud_cnt + 1;
      if (busy) busy_cnt = busy_cnt + 1;
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (par_err) perr_cnt = perr_cnt + 1;
      if (valid && frame_err) both_cnt = both_cnt + 1;
      if (valid) begin
         valid_cnt = valid_cnt + 1;
         last_valid_cyc = cyc;
         last_valid_dout = dout;
      end
   end

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rxd = b;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   // Caller must already be aligned just after a clock edge
   task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                             input logic par_bit, input int drop_en_at);
      last_start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) begin
         if (i + 1 == drop_en_at) en = 1'b0;
         drive_bit(data[i]);
      end
`ifdef RX_PARITY_EN
      drive_bit(par_bit);
`else
      if (par_bit === 1'bx) rxd = 1'b1;
`endif
      drive_bit(stop_bit);
   endtask

   task automatic test_reset();
      #5;
      checks++;
      if (dout !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_hold: dout=%h valid=%b ferr=%b busy=%b, want 00/0/0/0", dout, valid, frame_err, busy);
      end
      #5;
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (dout !== 8'h00 || valid !== 1'b0 || frame_err !== 1'b0 ||
             par_err !== 1'b0 || baud_en !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle: dout=%h v=%b fe=%b pe=%b be=%b busy=%b, want all 0",
                     dout, valid, frame_err, par_err, baud_en, busy);
         end
      end
   endtask

   task automatic test_good_frame();
      int b0, v0;
      en = 1'b1;
      align();
      b0 = baud_cnt;
      v0 = valid_cnt;
      send_frame(8'hAA, 1'b1, ^8'hAA, -1);
      rxd = 1'b1;
      idle(4);
      checks++;
      if (baud_cnt - b0 != BAUD_GOOD) begin
         errors++;
         $display("[TB] FAIL good_baud: got %0d pulses, want %0d", baud_cnt - b0, BAUD_GOOD);
      end
      checks++;
      if (valid_cnt - v0 != 1) begin
         errors++;
         $display("[TB] FAIL good_valid: got %0d pulses, want 1", valid_cnt - v0);
      end
      checks++;
      if (last_valid_dout !== 8'hAA) begin
         errors++;
         $display("[TB] FAIL good_dout: got %h, want aa", last_valid_dout);
      end
      checks++;
      if (last_valid_cyc - last_start_cyc != LATENCY) begin
         errors++;
         $display("[TB] FAIL good_latency: got %0d clocks, want %0d", last_valid_cyc - last_start_cyc, LATENCY);
      end
   endtask

   task automatic test_glitch();
      int b0, v0, f0;
      align();
      b0 = baud_cnt;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      rxd = 1'b0;
      idle(4);
      rxd = 1'b1;
      idle(1);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL glitch_busy_high: busy=%b, want 1", busy);
      end
      idle(7);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL glitch_busy_low: busy=%b, want 0", busy);
      end
      idle(20);
      checks++;
      if (baud_cnt - b0 != 1 || valid_cnt - v0 != 0 || ferr_cnt - f0 != 0) begin
         errors++;
         $display("[TB] FAIL glitch_strobes: baud=%0d valid=%0d ferr=%0d, want 1/0/0",
                  baud_cnt - b0, valid_cnt - v0, ferr_cnt - f0);
      end
   endtask

   task automatic test_frame_error();
      int v0, f0;
      align();
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(8'h55, 1'b0, ^8'h55, -1);
      rxd = 1'b1;
      idle(40);
      checks++;
      if (ferr_cnt - f0 != 1 || valid_cnt - v0 != 0) begin
         errors++;
         $display("[TB] FAIL ferr_strobes: ferr=%0d valid=%0d, want 1/0", ferr_cnt - f0, valid_cnt - v0);
      end
      checks++;
      if (dout !== 8'hAA) begin
         errors++;
         $display("[TB] FAIL ferr_dout_hold: got %h, want aa", dout);
      end
   endtask

   task automatic test_back_to_back();
      int v0, f0;
      align();
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b1, ^8'h3C, -1);
      checks++;
      if (valid_cnt - v0 != 1 || last_valid_dout !== 8'h3C) begin
         errors++;
         $display("[TB] FAIL b2b_first: valid=%0d dout=%h, want 1/3c", valid_cnt - v0, last_valid_dout);
      end
      send_frame(8'hC3, 1'b1, ^8'hC3, -1);
      rxd = 1'b1;
      idle(4);
      checks++;
      if (valid_cnt - v0 != 2 || last_valid_dout !== 8'hC3 || ferr_cnt - f0 != 0) begin
         errors++;
         $display("[TB] FAIL b2b_second: valid=%0d dout=%h ferr=%0d, want 2/c3/0",
                  valid_cnt - v0, last_valid_dout, ferr_cnt - f0);
      end
   endtask

   task automatic test_enable();
      int b0, v0, u0;
      en = 1'b0;
      align();
      b0 = baud_cnt;
      v0 = valid_cnt;
      u0 = busy_cnt;
      send_frame(8'h0F, 1'b1, ^8'h0F, -1);
      rxd = 1'b1;
      idle(20);
      checks++;
      if (baud_cnt - b0 != 0 || valid_cnt - v0 != 0 || busy_cnt - u0 != 0) begin
         errors++;
         $display("[TB] FAIL en_off: baud=%0d valid=%0d busy=%0d, want 0/0/0",
                  baud_cnt - b0, valid_cnt - v0, busy_cnt - u0);
      end
      checks++;
      if (dout !== 8'hC3) begin
         errors++;
         $display("[TB] FAIL en_off_dout: got %h, want c3", dout);
      end
      en = 1'b1;
      b0 = baud_cnt;
      v0 = valid_cnt;
      send_frame(8'hF0, 1'b1, ^8'hF0, 4);
      rxd = 1'b1;
      idle(20);
      checks++;
      if (valid_cnt - v0 != 1 || last_valid_dout !== 8'hF0 || baud_cnt - b0 != BAUD_GOOD) begin
         errors++;
         $display("[TB] FAIL en_drop: valid=%0d dout=%h baud=%0d, want 1/f0/%0d",
                  valid_cnt - v0, last_valid_dout, baud_cnt - b0, BAUD_GOOD);
      end
   endtask

   task automatic test_reset_mid_frame();
      int b0, v0, f0;
      en = 1'b1;
      align();
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      idle(4);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL midrst_busy_before: busy=%b, want 1", busy);
      end
      #4;
      reset = 1'b0;
      #1;
      checks++;
      if (dout !== 8'h00 || busy !== 1'b0 || valid !== 1'b0 ||
          frame_err !== 1'b0 || baud_en !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_values: dout=%h busy=%b v=%b fe=%b be=%b, want 00/0/0/0/0",
                  dout, busy, valid, frame_err, baud_en);
      end
      rxd = 1'b1;
      idle(3);
      reset = 1'b1;
      b0 = baud_cnt;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      idle(200);
      checks++;
      if (baud_cnt - b0 != 0 || valid_cnt - v0 != 0 || ferr_cnt - f0 != 0 || dout !== 8'h00) begin
         errors++;
         $display("[TB] FAIL midrst_quiet: baud=%0d valid=%0d ferr=%0d dout=%h, want 0/0/0/00",
                  baud_cnt - b0, valid_cnt - v0, ferr_cnt - f0, dout);
      end
   endtask

`ifdef RX_PARITY_EN
   task automatic test_parity();
      int v0, p0;
      align();
      v0 = valid_cnt;
      p0 = perr_cnt;
      send_frame(8'h07, 1'b1, 1'b1, -1);
      rxd = 1'b1;
      idle(4);
      checks++;
      if (valid_cnt - v0 != 1 || last_valid_dout !== 8'h07 || perr_cnt - p0 != 0) begin
         errors++;
         $display("[TB] FAIL par_good: valid=%0d dout=%h perr=%0d, want 1/07/0",
                  valid_cnt - v0, last_valid_dout, perr_cnt - p0);
      end
      v0 = valid_cnt;
      send_frame(8'h07, 1'b1, 1'b0, -1);
      rxd = 1'b1;
      idle(4);
      checks++;
      if (valid_cnt - v0 != 0 || perr_cnt - p0 != 1 || dout !== 8'h07) begin
         errors++;
         $display("[TB] FAIL par_bad: valid=%0d perr=%0d dout=%h, want 0/1/07",
                  valid_cnt - v0, perr_cnt - p0, dout);
      end
   endtask
`else
   task automatic test_parity();
      checks++;
      if (perr_cnt != 0) begin
         errors++;
         $display("[TB] FAIL par_tied: got %0d par_err pulses, want 0", perr_cnt);
      end
   endtask
`endif

   task automatic test_exclusive();
      checks++;
      if (both_cnt != 0) begin
         errors++;
         $display("[TB] FAIL valid_ferr_excl: got %0d overlaps, want 0", both_cnt);
      end
   endtask

   initial begin
      reset = 1'b0;
      rxd   = 1'b1;
      en    = 1'b0;
      test_reset();
      test_good_frame();
      test_glitch();
      test_frame_error();
      test_back_to_back();
      test_enable();
      test_reset_mid_frame();
      test_parity();
      test_exclusive();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
